snitch_tcdm_bank_ctrl: RTL and testbench
========================================

Name: snitch_tcdm_bank_ctrl

Overview:
Per-bank controller in front of one TCDM SRAM bank with 1-cycle read latency. It shares the bank between NumReq requesters using a round-robin arbiter and routes each response back to the requester that issued it. It also contains a clear sequencer that zero-fills the whole bank after reset or on command. One instance per bank sits between the cluster interconnect and the data memory macro.

Parameters:
TCDMDepth, 1024, words per bank
NarrowDataWidth, 64, bank word width in bits
NumReq, 4, requesters sharing the bank (>=2)
ClearOnReset, 1, 1: start a clear sequence when reset is released
AddrWidth, $clog2(TCDMDepth), derived word-address width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  pulse: start a clear sequence
busy_o  out  1  high while clearing
req_valid_i  in  NumReq  per-requester request valid
req_ready_o  out  NumReq  per-requester grant (one-hot or zero)
req_addr_i  in  NumReq x AddrWidth  word address
req_we_i  in  NumReq  1 = write
req_be_i  in  NumReq x NarrowDataWidth/8  byte enables
req_wdata_i  in  NumReq x NarrowDataWidth  write data
rsp_valid_o  out  NumReq  response valid, one cycle after grant
rsp_data_o  out  NarrowDataWidth  read data, shared by all requesters
mem_cs_o  out  1  bank chip select
mem_add_o  out  AddrWidth  bank address
mem_wen_o  out  1  bank write enable
mem_be_o  out  NarrowDataWidth/8  bank byte enables
mem_wdata_o  out  NarrowDataWidth  bank write data
mem_rdata_i  in  NarrowDataWidth  bank read data, valid the cycle after a read

Behaviour:
- Reset values: req_ready_o=0, rsp_valid_o=0, rsp_data_o=0, mem_cs_o=0, round-robin pointer=0, clear counter=0.
- While reset is asserted, busy_o=ClearOnReset. After reset, the FSM state is CLEAR if ClearOnReset=1, else RUN.
- FSM states are CLEAR and RUN.
- CLEAR state:
  - Each cycle drives mem_cs_o=1, mem_wen_o=1, mem_be_o all ones, mem_wdata_o=0, mem_add_o=counter.
  - The counter increments each cycle. When the write to TCDMDepth-1 is issued, the counter returns to 0 and the next state is RUN.
  - A full clear takes exactly TCDMDepth cycles.
  - busy_o=1 and req_ready_o=0 throughout.
  - clear_i is ignored.
- RUN state:
  - busy_o=0.
  - Arbitration is combinational in the same cycle. Among requesters with req_valid_i set, grant the first index at or after the pointer, wrapping modulo NumReq.
  - req_ready_o[g]=1 only for the granted index g.
  - mem_* carry requester g's fields, with mem_cs_o=1 and mem_wen_o=req_we_i[g].
  - After a grant, the pointer becomes (g+1) mod NumReq. With no valid request, the pointer holds and mem_cs_o=0.
  - Requesters must hold their request until granted. Fields are sampled only at grant.
- clear_i=1 in RUN:
  - No grant is issued that cycle.
  - The next state is CLEAR, starting at address 0.
- Response pipeline:
  - Registers granted index and write flag.
  - In the cycle after a grant, rsp_valid_o[g]=1 for both reads and writes (writes are acknowledged).
  - rsp_data_o=mem_rdata_i for reads and 0 for writes.
  - At most one rsp_valid_o bit is set.
  - A grant in the last RUN cycle before CLEAR still produces its response in the first CLEAR cycle.
- Back-to-back grants to the same or different requesters every cycle are supported. Throughput is 1 access per cycle.
- Reset mid-clear aborts the sequence. Restart follows ClearOnReset.

Optional Feature:
Macro SNITCH_TCDM_BANK_CTRL_PERF_EN.
- Defined:
  - Adds output port conflict_cnt_o (32 bits, reset 0).
  - Increments by (number of valid requesters - 1) in every RUN cycle with at least 2 valid requesters.
  - Saturates at 2^32-1. It is not cleared by clear_i.
- Undefined: port and logic are absent. All other behaviour is identical.

Test Plan:
- Reset with ClearOnReset=1, TCDMDepth=16 -> busy_o high exactly 16 cycles, addresses 0..15 written with 0 and be all ones. Then a read of addr 5 returns 0.
- Requester 1 writes 0xDEADBEEF_CAFEF00D to addr 7 with be=0xFF, then reads addr 7 -> rsp_valid_o[1] one cycle after each grant. Read data is 0xDEADBEEF_CAFEF00D; write response data is 0.
- All 4 requesters hold valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3. Each rsp_valid_o arrives one cycle after its grant.
- Write 0xFF..FF to addr 3 with be=0x0F, after clear -> read returns 0x00000000_FFFFFFFF.
- Grant a read to requester 2, and assert clear_i in the following cycle -> requester 2 still gets its response. No grants for TCDMDepth cycles, then arbitration resumes.
- PERF_EN defined: 3 requesters valid for 5 cycles -> conflict_cnt_o=10. Assert rst_ni low mid-clear -> all outputs at reset values and the counter restarts at 0.

Source files
------------

// File: rtl/snitch_tcdm_bank_ctrl.sv
// -----------------------------------------------------------------------------
// snitch_tcdm_bank_ctrl
//
// Per-bank controller in front of one single-ported TCDM SRAM bank with a
// 1-cycle read latency. NumReq requesters share the bank through a
// round-robin arbiter, and each response is routed back to the requester that
// issued it. A clear sequencer zero-fills the whole bank after reset (when
// ClearOnReset=1) or when clear_i is pulsed.
//
// Optional feature (macro SNITCH_TCDM_BANK_CTRL_PERF_EN):
//   adds conflict_cnt_o, a saturating 32-bit count of arbitration losers.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   clear_i              pulse: start a clear sequence (ignored while clearing)
//   busy_o               high while the clear sequence runs
//   conflict_cnt_o       (PERF_EN only) accumulated arbitration conflicts
//   req_valid_i          per-requester request valid
//   req_ready_o          per-requester grant, one-hot or zero
//   req_addr_i           per-requester word address
//   req_we_i             per-requester write enable
//   req_be_i             per-requester byte enables
//   req_wdata_i          per-requester write data
//   rsp_valid_o          per-requester response valid, one cycle after grant
//   rsp_data_o           read data (0 for write acknowledges), shared
//   mem_cs_o .. mem_wdata_o  SRAM macro request side
//   mem_rdata_i          SRAM read data, valid the cycle after a read
// -----------------------------------------------------------------------------
module snitch_tcdm_bank_ctrl #(
  parameter int unsigned TCDMDepth       = 1024,
  parameter int unsigned NarrowDataWidth = 64,
  parameter int unsigned NumReq          = 4,
  parameter bit          ClearOnReset    = 1'b1,
  parameter int unsigned AddrWidth       = $clog2(TCDMDepth),
  localparam int unsigned BeWidth        = NarrowDataWidth / 8,
  localparam int unsigned IdxWidth       = $clog2(NumReq)
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      clear_i,
  output logic                                      busy_o,
`ifdef SNITCH_TCDM_BANK_CTRL_PERF_EN
  output logic [31:0]                               conflict_cnt_o,
`endif
  input  logic [NumReq-1:0]                         req_valid_i,
  output logic [NumReq-1:0]                         req_ready_o,
  input  logic [NumReq-1:0][AddrWidth-1:0]          req_addr_i,
  input  logic [NumReq-1:0]                         req_we_i,
  input  logic [NumReq-1:0][BeWidth-1:0]            req_be_i,
  input  logic [NumReq-1:0][NarrowDataWidth-1:0]    req_wdata_i,
  output logic [NumReq-1:0]                         rsp_valid_o,
  output logic [NarrowDataWidth-1:0]                rsp_data_o,
  output logic                                      mem_cs_o,
  output logic [AddrWidth-1:0]                      mem_add_o,
  output logic                                      mem_wen_o,
  output logic [BeWidth-1:0]                        mem_be_o,
  output logic [NarrowDataWidth-1:0]                mem_wdata_o,
  input  logic [NarrowDataWidth-1:0]                mem_rdata_i
);

  typedef enum logic {
    StClear = 1'b0,
    StRun   = 1'b1
  } state_e;

  localparam state_e ResetState = ClearOnReset ? StClear : StRun;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   cnt_q, cnt_d;
  logic [IdxWidth-1:0]    ptr_q, ptr_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [IdxWidth-1:0]    rsp_idx_q, rsp_idx_d;
  logic                   rsp_we_q, rsp_we_d;

  // Arbiter result and raw (pre-reset-gating) request-side outputs.
  logic                   gnt_valid;
  logic [IdxWidth-1:0]    gnt_idx;
  logic [IdxWidth-1:0]    cand;
  logic                   grant;
  logic [NumReq-1:0]      ready_raw;
  logic                   cs_raw;

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: first valid index at or after ptr_q, modulo NumReq.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise a path that skips the assignment infers a latch.
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = IdxWidth'((32'(ptr_q) + k) % NumReq);
      if (!gnt_valid && req_valid_i[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: next state, counters and SRAM request mux.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    busy_o      = 1'b0;
    grant       = 1'b0;
    ready_raw   = '0;
    cs_raw      = 1'b0;
    mem_add_o   = '0;
    mem_wen_o   = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;

    unique case (state_q)
      StClear: begin
        busy_o    = 1'b1;
        cs_raw    = 1'b1;
        mem_wen_o = 1'b1;
        mem_be_o  = '1;
        mem_add_o = cnt_q;
        cnt_d     = cnt_q + AddrWidth'(1);
        if (cnt_q == AddrWidth'(TCDMDepth - 1)) begin
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (clear_i) begin
          // A clear request pre-empts arbitration for this cycle.
          state_d = StClear;
          cnt_d   = '0;
        end else if (gnt_valid) begin
          grant              = 1'b1;
          ready_raw[gnt_idx] = 1'b1;
          cs_raw             = 1'b1;
          mem_add_o          = req_addr_i[gnt_idx];
          mem_wen_o          = req_we_i[gnt_idx];
          mem_be_o           = req_be_i[gnt_idx];
          mem_wdata_o        = req_wdata_i[gnt_idx];
          ptr_d              = (gnt_idx == IdxWidth'(NumReq - 1)) ? '0
                                                                  : gnt_idx + IdxWidth'(1);
        end
      end
      default: state_d = ResetState;
    endcase
  end

  // The FSM state already sits in its reset value during reset, but a RUN
  // reset state would otherwise let valid requests reach the SRAM and the
  // requesters while rst_ni is low.
  assign req_ready_o = rst_ni ? ready_raw : '0;
  assign mem_cs_o    = rst_ni & cs_raw;

  // Response pipeline follows the SRAM's 1-cycle latency.
  assign rsp_valid_d = grant;
  assign rsp_idx_d   = gnt_idx;
  assign rsp_we_d    = req_we_i[gnt_idx];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ResetState;
      cnt_q       <= '0;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_we_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_we_q    <= rsp_we_d;
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    if (rsp_valid_q) rsp_valid_o[rsp_idx_q] = 1'b1;
  end

  // Writes are acknowledged with zero data.
  assign rsp_data_o = (rsp_valid_q && !rsp_we_q) ? mem_rdata_i : '0;

`ifdef SNITCH_TCDM_BANK_CTRL_PERF_EN
  // ---------------------------------------------------------------------------
  // Conflict counter: adds the number of losing requesters in every RUN cycle
  // with contention. Saturates, and survives clear sequences.
  // ---------------------------------------------------------------------------
  logic [31:0] conflict_cnt_q, conflict_cnt_d;
  logic [32:0] conflict_sum;
  int unsigned num_valid;

  always_comb begin
    num_valid      = $countones(req_valid_i);
    conflict_sum   = {1'b0, conflict_cnt_q} + 33'(num_valid) - 33'd1;
    conflict_cnt_d = conflict_cnt_q;
    if (state_q == StRun && num_valid >= 2) begin
      conflict_cnt_d = conflict_sum[32] ? '1 : conflict_sum[31:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) conflict_cnt_q <= '0;
    else         conflict_cnt_q <= conflict_cnt_d;
  end

  assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_snitch_tcdm_bank_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snitch_tcdm_bank_ctrl
//
// Self-checking bench for snitch_tcdm_bank_ctrl (TCDMDepth=16, 64-bit words,
// 4 requesters, ClearOnReset=1). A behavioural SRAM stands in for the macro;
// a transaction-level reference model (array memory, integer round-robin
// pointer, pending-response record) predicts every cycle's outputs.
// -----------------------------------------------------------------------------
module tb_snitch_tcdm_bank_ctrl;

  localparam int N  = 4;
  localparam int D  = 16;
  localparam int AW = 4;
  localparam int DW = 64;
  localparam int BW = DW / 8;

  logic                   clk_i   = 1'b0;
  logic                   rst_ni  = 1'b1;
  logic                   clear_i = 1'b0;
  logic                   busy_o;
  logic [N-1:0]           req_valid = '0;
  logic [N-1:0]           req_ready_o;
  logic [N-1:0][AW-1:0]   req_addr  = '0;
  logic [N-1:0]           req_we    = '0;
  logic [N-1:0][BW-1:0]   req_be    = '0;
  logic [N-1:0][DW-1:0]   req_wdata = '0;
  logic [N-1:0]           rsp_valid_o;
  logic [DW-1:0]          rsp_data_o;
  logic                   mem_cs_o;
  logic [AW-1:0]          mem_add_o;
  logic                   mem_wen_o;
  logic [BW-1:0]          mem_be_o;
  logic [DW-1:0]          mem_wdata_o;
  logic [DW-1:0]          sram_rdata = '0;
`ifdef SNITCH_TCDM_BANK_CTRL_PERF_EN
  logic [31:0]            conflict_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  snitch_tcdm_bank_ctrl #(
    .TCDMDepth      (D),
    .NarrowDataWidth(DW),
    .NumReq         (N),
    .ClearOnReset   (1'b1)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clear_i       (clear_i),
    .busy_o        (busy_o),
`ifdef SNITCH_TCDM_BANK_CTRL_PERF_EN
    .conflict_cnt_o(conflict_cnt_o),
`endif
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready_o),
    .req_addr_i    (req_addr),
    .req_we_i      (req_we),
    .req_be_i      (req_be),
    .req_wdata_i   (req_wdata),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_data_o    (rsp_data_o),
    .mem_cs_o      (mem_cs_o),
    .mem_add_o     (mem_add_o),
    .mem_wen_o     (mem_wen_o),
    .mem_be_o      (mem_be_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_rdata_i   (sram_rdata)
  );

  // Behavioural SRAM macro: byte-masked write, 1-cycle read latency.
  logic [DW-1:0] sram [D];
  always @(posedge clk_i) begin
    if (mem_cs_o) begin
      if (mem_wen_o) begin
        for (int b = 0; b < BW; b++)
          if (mem_be_o[b]) sram[mem_add_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        sram_rdata <= sram[mem_add_o];
      end
    end
  end

  // Reference model state.
  logic [DW-1:0] m_mem [D];
  bit            m_clearing;
  int            m_clr_addr;
  int            m_ptr;
  bit            m_rsp_pend;
  int            m_rsp_idx;
  logic [DW-1:0] m_rsp_data;
  longint        m_conf;

  // Observations from the most recent cycle, for directed checks.
  int            obs_grant;
  logic [N-1:0]  obs_rsp_valid;
  logic [DW-1:0] obs_rsp_data;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    else             n_pass++;
  endtask

  // One clock cycle: compare outputs at the falling edge against the model,
  // advance the model, then step past the rising edge and retire the grant.
  task automatic cycle();
    int g;
    int nv;
    logic [N-1:0] exp_v;
    g = -1;
    @(negedge clk_i);

    exp_v = '0;
    if (m_rsp_pend) exp_v[m_rsp_idx] = 1'b1;
    obs_rsp_valid = rsp_valid_o;
    obs_rsp_data  = rsp_data_o;
    check("rsp_valid", 64'(rsp_valid_o), 64'(exp_v));
    check("rsp_data", rsp_data_o, m_rsp_pend ? m_rsp_data : 64'd0);
    m_rsp_pend = 1'b0;

    obs_grant = -1;
    for (int r = 0; r < N; r++) if (req_ready_o[r]) obs_grant = r;

    nv = $countones(req_valid);
    if (m_clearing) begin
      check("clr_busy",  64'(busy_o), 64'd1);
      check("clr_ready", 64'(req_ready_o), 64'd0);
      check("clr_cs",    64'(mem_cs_o), 64'd1);
      check("clr_wen",   64'(mem_wen_o), 64'd1);
      check("clr_add",   64'(mem_add_o), 64'(m_clr_addr));
      check("clr_be",    64'(mem_be_o), 64'hFF);
      check("clr_wdata", mem_wdata_o, 64'd0);
      m_mem[m_clr_addr] = '0;
      m_clr_addr++;
      if (m_clr_addr == D) begin
        m_clearing = 1'b0;
        m_clr_addr = 0;
      end
    end else begin
      check("run_busy", 64'(busy_o), 64'd0);
      if (nv >= 2) begin
        m_conf = m_conf + nv - 1;
        if (m_conf > 64'hFFFF_FFFF) m_conf = 64'hFFFF_FFFF;
      end
      if (clear_i) begin
        check("clrreq_ready", 64'(req_ready_o), 64'd0);
        check("clrreq_cs",    64'(mem_cs_o), 64'd0);
        m_clearing = 1'b1;
        m_clr_addr = 0;
      end else begin
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        if (g < 0) begin
          check("idle_ready", 64'(req_ready_o), 64'd0);
          check("idle_cs",    64'(mem_cs_o), 64'd0);
        end else begin
          exp_v    = '0;
          exp_v[g] = 1'b1;
          check("gnt_ready", 64'(req_ready_o), 64'(exp_v));
          check("gnt_cs",    64'(mem_cs_o), 64'd1);
          check("gnt_add",   64'(mem_add_o), 64'(req_addr[g]));
          check("gnt_wen",   64'(mem_wen_o), 64'(req_we[g]));
          check("gnt_be",    64'(mem_be_o), 64'(req_be[g]));
          check("gnt_wdata", mem_wdata_o, req_wdata[g]);
          m_ptr      = (g + 1) % N;
          m_rsp_pend = 1'b1;
          m_rsp_idx  = g;
          if (req_we[g]) begin
            for (int b = 0; b < BW; b++)
              if (req_be[g][b]) m_mem[req_addr[g]][8*b +: 8] = req_wdata[g][8*b +: 8];
            m_rsp_data = '0;
          end else begin
            m_rsp_data = m_mem[req_addr[g]];
          end
        end
      end
    end
`ifdef SNITCH_TCDM_BANK_CTRL_PERF_EN
    check("conflict_cnt", 64'(conflict_cnt_o), 64'(m_conf));
`endif

    @(posedge clk_i);
    #1;
    if (g >= 0) req_valid[g] = 1'b0;
    clear_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    repeat (2) begin
      @(negedge clk_i);
      check("rst_busy",      64'(busy_o), 64'd1);
      check("rst_ready",     64'(req_ready_o), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
      check("rst_rsp_data",  rsp_data_o, 64'd0);
      check("rst_cs",        64'(mem_cs_o), 64'd0);
`ifdef SNITCH_TCDM_BANK_CTRL_PERF_EN
      check("rst_conflict",  64'(conflict_cnt_o), 64'd0);
`endif
    end
    @(posedge clk_i);
    #1;
    rst_ni     = 1'b1;
    m_clearing = 1'b1;
    m_clr_addr = 0;
    m_ptr      = 0;
    m_rsp_pend = 1'b0;
    m_conf     = 0;
  endtask

  // Raise one request and step cycles until it is granted (bounded).
  task automatic issue(input int r, input bit we, input int a,
                       input logic [BW-1:0] be, input logic [DW-1:0] d);
    req_we[r]    = we;
    req_addr[r]  = AW'(a);
    req_be[r]    = be;
    req_wdata[r] = d;
    req_valid[r] = 1'b1;
    for (int t = 0; t < 2 * N && req_valid[r]; t++) cycle();
    if (req_valid[r]) begin
      check("grant_timeout", 64'(req_valid[r]), 64'd0);
      req_valid[r] = 1'b0;
    end
  endtask

  task automatic rand_phase(input int n, input int clr_den);
    for (int i = 0; i < n; i++) begin
      for (int r = 0; r < N; r++) begin
        if (!req_valid[r] && $urandom_range(0, 2) == 0) begin
          req_we[r]    = 1'($urandom_range(0, 1));
          req_addr[r]  = AW'($urandom_range(0, D - 1));
          req_be[r]    = BW'($urandom);
          req_wdata[r] = {$urandom, $urandom};
          req_valid[r] = 1'b1;
        end
      end
      clear_i = ($urandom_range(0, clr_den - 1) == 0);
      cycle();
    end
  endtask

  initial begin
    // Start the macro with garbage so the clear sequence has work to do.
    for (int i = 0; i < D; i++) begin
      sram[i]  = {$urandom, $urandom};
      m_mem[i] = sram[i];
    end
    m_clearing = 1'b0; m_clr_addr = 0; m_ptr = 0;
    m_rsp_pend = 1'b0; m_rsp_idx = 0; m_rsp_data = '0; m_conf = 0;

    #1;
    do_reset();

    // Clear after reset: D busy cycles, then the first RUN cycle.
    repeat (D) cycle();
    cycle();

    // All requesters continuously valid: grant order 0,1,2,3,0,1,2,3.
    for (int r = 0; r < N; r++) begin
      req_we[r] = 1'b0; req_addr[r] = AW'(r); req_be[r] = '1; req_wdata[r] = '0;
    end
    for (int k = 0; k < 8; k++) begin
      req_valid = '1;
      cycle();
      check("rr_order", 64'(obs_grant), 64'(k % N));
    end
    req_valid = '0;
    cycle();

    // Read of a cleared word returns zero.
    issue(0, 1'b0, 5, '1, '0);
    cycle();
    check("rd5_data", obs_rsp_data, 64'd0);

    // Full-word write then read back through requester 1.
    issue(1, 1'b1, 7, 8'hFF, 64'hDEADBEEF_CAFEF00D);
    cycle();
    check("wr7_rsp_valid", 64'(obs_rsp_valid), 64'h2);
    check("wr7_rsp_data",  obs_rsp_data, 64'd0);
    issue(1, 1'b0, 7, 8'hFF, '0);
    cycle();
    check("rd7_rsp_valid", 64'(obs_rsp_valid), 64'h2);
    check("rd7_rsp_data",  obs_rsp_data, 64'hDEADBEEF_CAFEF00D);

    // Partial-byte write over a cleared word.
    issue(0, 1'b1, 3, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF);
    cycle();
    issue(0, 1'b0, 3, 8'hFF, '0);
    cycle();
    check("rd3_partial", obs_rsp_data, 64'h00000000_FFFFFFFF);

    // Read granted to requester 2, clear_i in the following cycle.
    issue(2, 1'b0, 7, 8'hFF, '0);
    clear_i = 1'b1;
    cycle();
    check("clr_rsp_valid", 64'(obs_rsp_valid), 64'h4);
    check("clr_rsp_data",  obs_rsp_data, 64'hDEADBEEF_CAFEF00D);
    for (int r = 0; r < N; r++) begin
      req_we[r] = 1'b0; req_addr[r] = AW'(r + 4); req_valid[r] = 1'b1;
    end
    for (int i = 0; i < D; i++) begin
      cycle();
      check("clr_no_grant", 64'(obs_grant), 64'(-1));
    end
    cycle();
    check("resume_grant", 64'(obs_grant >= 0), 64'd1);

    // Randomized traffic with occasional clear pulses.
    rand_phase(400, 64);

    // Reset in the middle of a clear sequence.
    req_valid = '0;
    clear_i   = 1'b1;
    cycle();
    repeat (5) cycle();
    do_reset();
    rand_phase(150, 48);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
